shift_arb: RTL and testbench

- Shares one 32-bit barrel shifter between two requesters, e.g. the ALU issue path (port 0) and the multiply/divide microsequencer (port 1).
- Arbitrates round-robin, performs SLL/SRL/SRA with a 5-bit shift amount, and returns the result through a single registered response slot.
- Uses valid/ready handshakes on all sides.
- Latency is 1 cycle from accept to response valid. Throughput is 1 op/cycle when the response is drained every cycle.

---
 rtl/shift_arb.sv | 107 ++++++++++
 tb/tb_shift_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arb.sv
// Round-robin arbiter sharing one 32-bit barrel shifter between two requesters,
// with a single registered response slot and valid/ready on every side.
module shift_arb #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [4:0]       req0_shamt,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [4:0]       req1_shamt,
   input  logic [1:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_id
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_last_grant;
   logic [WIDTH-1:0] r_data;
   logic             r_id;

   logic             w_free;
   logic             w_grant0;
   logic             w_grant1;
   logic             w_accept;
   logic             w_sel;
   logic [WIDTH-1:0] w_a;
   logic [4:0]       w_shamt;
   logic [1:0]       w_op;
   logic [WIDTH-1:0] w_result;

   // Priority goes to the port that did not win the last accept.
   always_comb begin
      w_grant0 = req0_valid & (~req1_valid | r_last_grant);
      w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_EMPTY;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
         S_FULL:  if (rsp_ready && !w_accept) w_state_nxt = S_EMPTY;
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   // Output / handshake logic.
   always_comb begin
      w_free     = (r_state == S_EMPTY) | rsp_ready;
      req0_ready = w_free & w_grant0;
      req1_ready = w_free & w_grant1;
      w_accept   = req0_ready | req1_ready;
      rsp_valid  = (r_state == S_FULL);
   end

   // Operand mux driven by the grant, then the shifter itself.
   always_comb begin
      w_sel   = w_grant1;
      w_a     = w_sel ? req1_a     : req0_a;
      w_shamt = w_sel ? req1_shamt : req0_shamt;
      w_op    = w_sel ? req1_op    : req0_op;
      case (w_op)
         OP_SLL:  w_result = w_a << w_shamt;
         OP_SRL:  w_result = w_a >> w_shamt;
         OP_SRA:  w_result = WIDTH'($signed(w_a) >>> w_shamt);
         default: w_result = w_a;
      endcase
   end

   // Response payload and round-robin pointer update only on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data       <= '0;
         r_id         <= 1'b0;
         r_last_grant <= 1'b1;
      end else if (w_accept) begin
         r_data       <= w_result;
         r_id         <= w_sel;
         r_last_grant <= w_sel;
      end
   end

   assign rsp_data = r_data;
   assign rsp_id   = r_id;

endmodule

// File: tb/tb_shift_arb.sv
// Self-checking bench for shift_arb: directed scenarios followed by random
// traffic, compared each cycle against a transaction-level reference model.
module tb_shift_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req1_a;
   logic [4:0]  req0_shamt, req1_shamt;
   logic [1:0]  req0_op, req1_op;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_data;

   always #5 clk = ~clk;

   shift_arb #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
      .req0_shamt(req0_shamt), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
      .req1_shamt(req1_shamt), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: slot contents and who was served last.
   logic        m_full, m_last, m_id;
   logic [31:0] m_data;
   logic        acc0, acc1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Shift as arithmetic: multiply / divide by 2**s, SRA via complement trick.
   function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                             input logic [1:0] op);
      logic [63:0] p;
      logic [63:0] prod;
      p = 64'd1;
      for (int i = 0; i < int'(s); i++) p = p * 64'd2;
      prod = {32'd0, a} * p;
      case (op)
         2'd0:    return prod[31:0];
         2'd1:    return 32'({32'd0, a} / p);
         2'd2:    return a[31] ? ~32'({32'd0, ~a} / p) : 32'({32'd0, a} / p);
         default: return a;
      endcase
   endfunction

   task automatic model_reset();
      m_full = 1'b0; m_last = 1'b1; m_id = 1'b0; m_data = 32'd0;
   endtask

   // One clock: entered at posedge+1, checks mid-cycle, advances model at the edge.
   task automatic cycle();
      logic free, both, anyv, win, e0, e1;
      #4;
      free = !m_full || rsp_ready;
      both = req0_valid && req1_valid;
      anyv = req0_valid || req1_valid;
      win  = both ? !m_last : req1_valid;
      e0   = free && anyv && !win;
      e1   = free && anyv && win;
      chk("req0_ready", 32'(req0_ready), 32'(e0));
      chk("req1_ready", 32'(req1_ready), 32'(e1));
      chk("rsp_valid",  32'(rsp_valid),  32'(m_full));
      chk("rsp_data",   rsp_data,        m_data);
      chk("rsp_id",     32'(rsp_id),     32'(m_id));
      @(posedge clk);
      acc0 = e0; acc1 = e1;
      if (e0 || e1) begin
         m_data = win ? ref_shift(req1_a, req1_shamt, req1_op)
                      : ref_shift(req0_a, req0_shamt, req0_op);
         m_id   = win;
         m_last = win;
         m_full = 1'b1;
      end else if (m_full && rsp_ready) begin
         m_full = 1'b0;
      end
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      req0_a = '0; req1_a = '0; req0_shamt = '0; req1_shamt = '0;
      req0_op = '0; req1_op = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      idle_inputs();
      acc0 = 0; acc1 = 0;
      #1;
      do_reset();

      // Reset state.
      #4;
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_data",  rsp_data,       32'd0);
      chk("rst_id",    32'(rsp_id),    32'd0);
      @(posedge clk); #1;

      // Single request on port 0: SLL by 4.
      req0_valid = 1; req0_a = 32'h0000_0001; req0_shamt = 5'd4; req0_op = 2'd0;
      rsp_ready = 1;
      cycle();
      chk("t1_acc0", 32'(acc0), 32'd1);
      req0_valid = 0;
      chk("t1_valid", 32'(rsp_valid), 32'd1);
      chk("t1_data",  rsp_data,       32'h0000_0010);
      chk("t1_id",    32'(rsp_id),    32'd0);
      cycle();

      // Continuous contention from reset: grants alternate starting with port 0.
      do_reset();
      rsp_ready = 1;
      req0_valid = 1; req0_a = 32'h8000_0000; req0_shamt = 5'd31; req0_op = 2'd2;
      req1_valid = 1; req1_a = 32'h8000_0000; req1_shamt = 5'd31; req1_op = 2'd1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("alt_id",   32'(rsp_id), 32'(i % 2));
         chk("alt_data", rsp_data, (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0001);
      end
      req0_valid = 0; req1_valid = 0;
      cycle();

      // Backpressure: port 1 PASS fills the slot, then port 0 waits 3 stalled cycles.
      req1_valid = 1; req1_a = 32'hDEAD_BEEF; req1_shamt = 5'd7; req1_op = 2'd3;
      rsp_ready = 1;
      cycle();
      req1_valid = 0;
      req0_valid = 1; req0_a = 32'h0000_0001; req0_shamt = 5'd1; req0_op = 2'd0;
      rsp_ready = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_ready0", 32'(acc0),  32'd0);
         chk("bp_data",   rsp_data,   32'hDEAD_BEEF);
      end
      rsp_ready = 1;
      cycle();
      chk("bp_release", 32'(acc0), 32'd1);
      chk("bp_newdata", rsp_data,  32'h0000_0002);
      req0_valid = 0;
      cycle();

      // Boundary shift amounts.
      req0_valid = 1; req0_a = 32'h1234_5678;
      for (int op = 0; op < 3; op++) begin
         req0_shamt = 5'd0; req0_op = 2'(op);
         cycle();
         chk("shamt0", rsp_data, 32'h1234_5678);
      end
      req0_shamt = 5'd31; req0_op = 2'd0;
      cycle();
      chk("sll31", rsp_data, 32'h0000_0000);
      req0_valid = 0;
      cycle();

      // Stall under contention does not rotate priority.
      req1_valid = 1; req1_a = 32'h0000_00F0; req1_shamt = 5'd4; req1_op = 2'd1;
      cycle();
      req0_valid = 1; req0_a = 32'h0000_0003; req0_shamt = 5'd2; req0_op = 2'd0;
      req1_a = 32'h0000_0055; req1_op = 2'd3;
      rsp_ready = 0;
      for (int i = 0; i < 3; i++) cycle();
      rsp_ready = 1;
      cycle();
      chk("stall_rr_win0", 32'(acc0), 32'd1);
      chk("stall_rr_data", rsp_data, 32'h0000_000C);
      req0_valid = 0;
      cycle();
      chk("stall_rr_then1", 32'(acc1), 32'd1);
      req1_valid = 0;
      cycle();

      // Asynchronous reset while a response is held under backpressure.
      req0_valid = 1; req0_a = 32'hA5A5_0000; req0_shamt = 5'd8; req0_op = 2'd1;
      rsp_ready = 0;
      cycle();
      req0_valid = 0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(rsp_valid), 32'd0);
      chk("async_data",  rsp_data,       32'd0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      req0_valid = 1; req0_a = 32'h0000_0001; req0_shamt = 5'd3; req0_op = 2'd0;
      req1_valid = 1; req1_a = 32'h0000_0001; req1_shamt = 5'd3; req1_op = 2'd3;
      rsp_ready = 1;
      cycle();
      chk("post_rst_win0", 32'(acc0), 32'd1);
      req0_valid = 0; req1_valid = 0;
      cycle();

      // Random traffic honouring the hold-until-accepted rule.
      for (int n = 0; n < 400; n++) begin
         if (!req0_valid || acc0) begin
            req0_valid = ($urandom % 3) != 0;
            req0_a     = $urandom;
            req0_shamt = ($urandom % 4 == 0) ? 5'(($urandom % 2) * 31) : 5'($urandom);
            req0_op    = 2'($urandom);
         end
         if (!req1_valid || acc1) begin
            req1_valid = ($urandom % 3) != 0;
            req1_a     = $urandom;
            req1_shamt = ($urandom % 4 == 0) ? 5'(($urandom % 2) * 31) : 5'($urandom);
            req1_op    = 2'($urandom);
         end
         rsp_ready = ($urandom % 4) != 0;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
